// File: rtl/rr_pkt_arbiter_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM state
// encoding and the ctrl value that marks a payload word.
package rr_pkt_arbiter_pkg;

    // One-hot FSM encoding
    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_ARB = 3'b001,   // choosing the next queue, no read
        ST_HDR = 3'b010,   // forwarding module-header words (ctrl != 0)
        ST_PKT = 3'b100    // forwarding payload, waiting for the EOP word
    } state_t;

    // A word whose ctrl equals this value is payload; anything else is a
    // header word or, after payload has been seen, the EOP word.
    localparam int CTRL_NONE = 0;

endpackage : rr_pkt_arbiter_pkg

// File: rtl/rr_pkt_arbiter_rr_select.sv
// Combinational round-robin pick: starting just after the last served
// index, return the first requesting index (wrapping modulo N).
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // cand[k] is the queue index visited at rotation step k, i.e. last+1+k
    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign cand[gi] = IDX_W'((int'(last) + 1 + gi) % N);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest rotation step wins: walk from the far end so the nearest overrides
    always_comb begin
        found = 1'b0;
        idx   = last;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule : rr_select

// File: rtl/rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter. Merges NUM_QUEUES fallthrough FIFO
// heads into one registered stream; a grant lasts a whole packet so words
// of different queues never interleave.
module rr_pkt_arbiter
    import rr_pkt_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_QUEUES  = 4,
    parameter int Q_IDX_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_empty,
    output logic [NUM_QUEUES-1:0]            in_rd_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [Q_IDX_WIDTH-1:0]           cur_queue,
    output logic                             busy
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [Q_IDX_WIDTH-1:0]  ptr_reg;
    logic [Q_IDX_WIDTH-1:0]  cur_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [CTRL_WIDTH-1:0]   out_ctrl_reg;
    logic                    out_wr_reg;

    logic [DATA_WIDTH-1:0]   q_data [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0]   q_ctrl [NUM_QUEUES];
    logic [DATA_WIDTH-1:0]   head_data;
    logic [CTRL_WIDTH-1:0]   head_ctrl;
    logic                    head_empty;
    logic                    head_is_payload;
    logic                    fwd;
    logic                    sel_found;
    logic [Q_IDX_WIDTH-1:0]  sel_idx;

    // Split the packed FIFO head buses into per-queue words
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_unpack
            assign q_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign q_ctrl[gi] = in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH];
        end
    endgenerate

    // Head of the granted queue
    assign head_data       = q_data[cur_reg];
    assign head_ctrl       = q_ctrl[cur_reg];
    assign head_empty      = in_empty[cur_reg];
    assign head_is_payload = (head_ctrl == CTRL_WIDTH'(CTRL_NONE));

    // Round-robin choice among non-empty queues, starting after the last grant
    rr_select #(
        .N     (NUM_QUEUES),
        .IDX_W (Q_IDX_WIDTH)
    ) u_rr_select (
        .req   (~in_empty),
        .last  (ptr_reg),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // A word moves only while a packet is granted, downstream is ready and
    // the granted FIFO has data; reset blocks any read immediately.
    assign fwd = reset && (state_reg != ST_ARB) && out_rdy && !head_empty;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: HDR->PKT on the first payload word, PKT->ARB on EOP
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_ARB:  if (sel_found)                state_next = ST_HDR;
            ST_HDR:  if (fwd && head_is_payload)   state_next = ST_PKT;
            ST_PKT:  if (fwd && !head_is_payload)  state_next = ST_ARB;
            default:                               state_next = ST_ARB;
        endcase
    end

    // Outputs of the FSM: single-cycle read strobe on the granted queue only
    always_comb begin
        in_rd_en = '0;
        if (fwd) begin
            in_rd_en[cur_reg] = 1'b1;
        end
    end

    // Grant latch: pointer and current queue move together when ARB picks
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg <= Q_IDX_WIDTH'(NUM_QUEUES - 1);
            cur_reg <= '0;
        end else if ((state_reg == ST_ARB) && sel_found) begin
            ptr_reg <= sel_idx;
            cur_reg <= sel_idx;
        end
    end

    // Registered output stage; data follows the mux every cycle, out_wr
    // marks the cycles that actually carry a forwarded word
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_wr_reg   <= 1'b0;
            out_data_reg <= '0;
            out_ctrl_reg <= '0;
        end else begin
            out_wr_reg   <= fwd;
            out_data_reg <= head_data;
            out_ctrl_reg <= head_ctrl;
        end
    end

    assign out_wr    = out_wr_reg;
    assign out_data  = out_data_reg;
    assign out_ctrl  = out_ctrl_reg;
    assign cur_queue = cur_reg;
    assign busy      = (state_reg != ST_ARB);

    // Structural invariants
    a_rd_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(in_rd_en));
    a_state_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot(state_reg));
    a_no_rd_in_arb : assert property (@(posedge clk) disable iff (!reset)
        (state_reg == ST_ARB) |-> (in_rd_en == '0));

endmodule : rr_pkt_arbiter

// File: tb/tb_rr_pkt_arbiter.sv
// Self-checking bench for rr_pkt_arbiter: FIFO contents are modelled as
// queues, and a packet-level reference computes the expected read strobes
// and output words cycle by cycle.
module tb_rr_pkt_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int QW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]    in_empty;
    logic [NQ-1:0]    in_rd_en;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_wr;
    logic             out_rdy;
    logic [QW-1:0]    cur_queue;
    logic             busy;

    always #5 clk = ~clk;

    rr_pkt_arbiter #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (CW),
        .NUM_QUEUES  (NQ),
        .Q_IDX_WIDTH (QW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .cur_queue (cur_queue),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // FIFO contents per queue, plus a per-queue "pretend empty" override
    logic [DW-1:0] fd [NQ][$];
    logic [CW-1:0] fc [NQ][$];
    bit            hold [NQ];

    // Reference model: owner = -1 while arbitrating
    int            m_owner = -1;
    int            m_last  = NQ - 1;
    int            m_cur   = 0;
    bit            m_payload = 0;
    bit            e_wr = 0;
    bit            e_zero = 1;
    logic [DW-1:0] e_data = '0;
    logic [CW-1:0] e_ctrl = '0;
    int            pushed_pkts = 0;

    // Observation of the DUT output stream
    bit  obs_active = 0;
    bit  obs_payload = 0;
    int  obs_idle = 1000;
    int  obs_words = 0;
    int  obs_total_words = 0;
    int  obs_grants[$];
    int  obs_gaps[$];

    // DUT values captured at the last sampling edge
    logic [NQ-1:0] last_rd;
    logic          last_wr, last_busy;
    logic [QW-1:0] last_cur;
    logic [DW-1:0] last_data;
    logic [CW-1:0] last_ctrl;

    function automatic bit avail(int q);
        return (fd[q].size() > 0) && !hold[q];
    endfunction

    function automatic logic [NQ-1:0] model_rd();
        if (reset && (m_owner >= 0) && out_rdy && avail(m_owner))
            return NQ'(1 << m_owner);
        return '0;
    endfunction

    task automatic drive_inputs();
        for (int q = 0; q < NQ; q++) begin
            in_empty[q]           = !avail(q);
            in_data[q*DW +: DW]   = (fd[q].size() > 0) ? fd[q][0] : '0;
            in_ctrl[q*CW +: CW]   = (fc[q].size() > 0) ? fc[q][0] : '0;
        end
    endtask

    task automatic push_word(int q, logic [CW-1:0] c, logic [DW-1:0] d);
        fc[q].push_back(c);
        fd[q].push_back(d);
        drive_inputs();
    endtask

    // Packet of nhdr header words, npay payload words and one EOP word
    task automatic push_pkt(int q, int nhdr, int npay);
        for (int i = 0; i < nhdr; i++)
            push_word(q, CW'($urandom_range(1, 255)), {$urandom, $urandom});
        for (int i = 0; i < npay; i++)
            push_word(q, '0, {$urandom, $urandom});
        push_word(q, CW'($urandom_range(1, 255)), {$urandom, $urandom});
        pushed_pkts++;
    endtask

    task automatic clear_obs();
        obs_grants.delete();
        obs_gaps.delete();
        obs_total_words = 0;
        pushed_pkts = 0;
    endtask

    // One clock: compare at negedge, advance model at posedge, update FIFOs after
    task automatic tick();
        logic [NQ-1:0] exp_rd;
        int            pop_q;
        bit            found;
        int            qq;
        @(negedge clk);
        exp_rd    = model_rd();
        last_rd   = in_rd_en;
        last_wr   = out_wr;
        last_busy = busy;
        last_cur  = cur_queue;
        last_data = out_data;
        last_ctrl = out_ctrl;
        checks++;
        if (in_rd_en !== exp_rd) begin
            errors++;
            $display("FAIL rd_en @%0t: got %b expected %b", $time, in_rd_en, exp_rd);
        end
        checks++;
        if (busy !== (m_owner >= 0)) begin
            errors++;
            $display("FAIL busy @%0t: got %b expected %0d", $time, busy, m_owner >= 0);
        end
        checks++;
        if (cur_queue !== QW'(m_cur)) begin
            errors++;
            $display("FAIL cur_queue @%0t: got %0d expected %0d", $time, cur_queue, m_cur);
        end
        checks++;
        if (out_wr !== e_wr) begin
            errors++;
            $display("FAIL out_wr @%0t: got %b expected %b", $time, out_wr, e_wr);
        end
        if (e_wr || e_zero) begin
            checks++;
            if ({out_ctrl, out_data} !== {e_ctrl, e_data}) begin
                errors++;
                $display("FAIL out_word @%0t: got %h/%h expected %h/%h",
                         $time, out_ctrl, out_data, e_ctrl, e_data);
            end
        end
        // follow packets on the output stream
        if (out_wr === 1'b1) begin
            if (!obs_active) begin
                obs_active  = 1;
                obs_payload = 0;
                obs_words   = 0;
                obs_grants.push_back(int'(cur_queue));
                obs_gaps.push_back(obs_idle);
            end
            obs_words++;
            obs_total_words++;
            if (out_ctrl == '0) begin
                obs_payload = 1;
            end else if (obs_payload) begin
                obs_active = 0;
                obs_idle   = 0;
                $display("packet from queue %0d: %0d words @%0t", cur_queue, obs_words, $time);
            end
        end else if (!obs_active) begin
            obs_idle++;
        end

        @(posedge clk);
        pop_q = -1;
        if (!reset) begin
            m_owner = -1; m_last = NQ - 1; m_cur = 0; m_payload = 0;
            e_wr = 0; e_zero = 1; e_data = '0; e_ctrl = '0;
        end else begin
            e_zero = 0;
            e_wr   = (exp_rd != '0);
            if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= NQ; k++) begin
                    qq = (m_last + k) % NQ;
                    if (!found && avail(qq)) begin
                        found = 1; m_owner = qq; m_cur = qq; m_last = qq; m_payload = 0;
                    end
                end
            end else if (e_wr) begin
                e_data = fd[m_owner][0];
                e_ctrl = fc[m_owner][0];
                pop_q  = m_owner;
                if (e_ctrl == '0) m_payload = 1;
                else if (m_payload) m_owner = -1;
            end
        end
        #1;
        if (!reset) begin
            for (int q = 0; q < NQ; q++) begin
                fd[q].delete();
                fc[q].delete();
            end
        end else if (pop_q >= 0) begin
            void'(fd[pop_q].pop_front());
            void'(fc[pop_q].pop_front());
        end
        drive_inputs();
    endtask

    task automatic drain();
        int  budget = 2000;
        bit  pending = 1;
        while (pending && budget > 0) begin
            tick();
            budget--;
            pending = (m_owner >= 0) || e_wr;
            for (int q = 0; q < NQ; q++) if (fd[q].size() > 0) pending = 1;
        end
        checks++;
        if (pending) begin
            errors++;
            $display("FAIL drain_timeout: got pending traffic after 2000 cycles, expected idle");
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        obs_active = 0;
        obs_payload = 0;
        obs_idle = 1000;
        drive_inputs();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        out_rdy = 1'b1;
        for (int q = 0; q < NQ; q++) hold[q] = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        tick();
        tick();
        checks++;
        if ({last_wr, last_busy, last_cur, last_rd} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got wr=%b busy=%b cur=%0d rd=%b expected all 0",
                     last_wr, last_busy, last_cur, last_rd);
        end
        checks++;
        if ({last_ctrl, last_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0", last_ctrl, last_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_packet();
        int first = 0;
        clear_obs();
        push_word(0, 8'hFF, 64'h1000);
        push_word(0, 8'h00, 64'h1001);
        push_word(0, 8'h00, 64'h1002);
        push_word(0, 8'h00, 64'h1003);
        push_word(0, 8'h04, 64'h1004);
        for (int i = 1; i <= 8 && first == 0; i++) begin
            tick();
            if (last_wr === 1'b1) first = i;
        end
        checks++;
        if (first - 1 != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles expected 2", first - 1);
        end
        drain();
        checks++;
        if (obs_total_words != 5 || obs_grants.size() != 1) begin
            errors++;
            $display("FAIL single_words: got %0d words/%0d pkts expected 5/1",
                     obs_total_words, obs_grants.size());
        end else begin
            checks++;
            if (obs_grants[0] != 0) begin
                errors++;
                $display("FAIL single_queue: got %0d expected 0", obs_grants[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_obs();
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < NQ; q++) push_pkt(q, 1, 2);
        drain();
        checks++;
        if (obs_grants.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d packets expected 8", obs_grants.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_grants[i] != i % NQ) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, obs_grants[i], i % NQ);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_gaps[i] != 1) begin
                        errors++;
                        $display("FAIL rr_gap[%0d]: got %0d idle expected 1", i, obs_gaps[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        clear_obs();
        push_pkt(2, 1, 5);
        repeat (4) tick();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (last_rd !== '0) begin
                errors++;
                $display("FAIL stall_rd[%0d]: got %b expected 0000", i, last_rd);
            end
            if (i > 0) begin
                checks++;
                if (last_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_wr[%0d]: got %b expected 0", i, last_wr);
                end
            end
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (last_rd !== 4'b0100 || last_wr !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: got rd=%b wr=%b expected rd=0100 wr=0", last_rd, last_wr);
        end
        drain();
        checks++;
        if (obs_total_words != 7) begin
            errors++;
            $display("FAIL stall_words: got %0d expected 7", obs_total_words);
        end
    endtask

    task automatic test_empty_hold();
        clear_obs();
        push_pkt(1, 1, 6);
        repeat (4) tick();
        push_pkt(3, 2, 1);
        hold[1] = 1;
        drive_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (last_rd !== '0 || last_busy !== 1'b1 || last_cur !== 2'd1) begin
                errors++;
                $display("FAIL hold[%0d]: got rd=%b busy=%b cur=%0d expected rd=0000 busy=1 cur=1",
                         i, last_rd, last_busy, last_cur);
            end
        end
        hold[1] = 0;
        drive_inputs();
        drain();
        checks++;
        if (obs_grants.size() != 2 || obs_grants[0] != 1 || obs_grants[1] != 3) begin
            errors++;
            $display("FAIL hold_order: got %0d packets first=%0d expected 2 packets 1 then 3",
                     obs_grants.size(), (obs_grants.size() > 0) ? obs_grants[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[5] = '{2, 2, 2, 3, 0};
        clear_obs();
        for (int i = 0; i < 3; i++) push_pkt(2, 1, 2);
        drain();
        push_pkt(0, 1, 1);
        push_pkt(3, 1, 1);
        drain();
        checks++;
        if (obs_grants.size() != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d packets expected 5", obs_grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_grants[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, obs_grants[i], exp_q[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (obs_gaps[i] != 1) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d idle expected 1", i, obs_gaps[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midpkt();
        clear_obs();
        push_pkt(3, 1, 6);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (last_wr !== 1'b0 || last_busy !== 1'b0 || last_cur !== 2'd0) begin
            errors++;
            $display("FAIL midpkt_reset: got wr=%b busy=%b cur=%0d expected 0/0/0",
                     last_wr, last_busy, last_cur);
        end
        reset = 1'b1;
        obs_active = 0;
        obs_payload = 0;
        clear_obs();
        push_pkt(3, 1, 1);
        push_pkt(1, 1, 1);
        drain();
        checks++;
        if (obs_grants.size() != 2 || obs_grants[0] != 1) begin
            errors++;
            $display("FAIL midpkt_first: got %0d packets first=%0d expected 2 packets first=1",
                     obs_grants.size(), (obs_grants.size() > 0) ? obs_grants[0] : -1);
        end
    endtask

    task automatic test_random();
        int q;
        clear_obs();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                q = $urandom_range(0, NQ - 1);
                if (fd[q].size() < 20) push_pkt(q, $urandom_range(1, 2), $urandom_range(1, 4));
            end
            for (int k = 0; k < NQ; k++)
                if ($urandom_range(0, 15) == 0) hold[k] = ~hold[k];
            out_rdy = ($urandom_range(0, 3) != 0);
            drive_inputs();
            tick();
        end
        for (int k = 0; k < NQ; k++) hold[k] = 0;
        out_rdy = 1'b1;
        drive_inputs();
        drain();
        checks++;
        if (obs_grants.size() != pushed_pkts) begin
            errors++;
            $display("FAIL random_pkts: got %0d delivered expected %0d", obs_grants.size(), pushed_pkts);
        end
    endtask

    initial begin
        reset   = 1'b0;
        out_rdy = 1'b1;
        in_data = '0;
        in_ctrl = '0;
        in_empty = '1;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_empty_hold();
        test_back_to_back();
        test_reset_midpkt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_pkt_arbiter
